// File: rtl/uma_pkg.sv
// Shared types and helpers for the unaligned memory adapter: size codes,
// FSM state encoding and the two-word byte-enable mask.
package uma_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_e;

  // A dword request on a 4-byte backend degrades to a word access.
  function automatic int size_bytes(input logic [1:0] size, input int nb);
    case (size)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return 4;
      default: return (nb >= 8) ? 8 : 4;
    endcase
  endfunction

  // Low NB bits enable the first word, the next NB bits the second word.
  function automatic logic [15:0] be_mask(input logic [1:0] size, input int off, input int nb);
    logic [15:0] m;
    m = 16'((32'd1 << size_bytes(size, nb)) - 32'd1);
    return m << off;
  endfunction

endpackage

// File: rtl/uma_load_align.sv
// Load path: shifts the one- or two-word read window down to the requested
// byte offset, then truncates to the access size and zero/sign-extends.
module uma_load_align
  import uma_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]           word0,
  input  logic [DW-1:0]           word1,
  input  logic [$clog2(DW/8)-1:0] off,
  input  logic [1:0]              size,
  input  logic                    is_unsigned,
  output logic [DW-1:0]           result
);

  logic [DW-1:0] shifted;
  logic [DW-1:0] mask;
  logic [DW-1:0] top_bit;
  logic          sign;
  int            nbytes;

  always_comb begin
    nbytes  = size_bytes(size, DW/8);
    shifted = DW'({word1, word0} >> (8 * int'(off)));
    mask    = {DW{1'b1}} >> (DW - 8 * nbytes);
    top_bit = mask & ~(mask >> 1);
    sign    = ~is_unsigned & (|(shifted & top_bit));
    result  = (shifted & mask) | (sign ? ~mask : '0);
  end

endmodule

// File: rtl/unaligned_mem_adapter.sv
// CPU-to-backend adapter splitting word-crossing loads/stores into two aligned
// transactions. Define UMA_MISALIGN_TRAP_EN to trap crossing accesses instead.
//
// state   | meaning
// IDLE    | waiting for a CPU request
// RD_REQ  | read strobe held until backend raises busy
// RD_WAIT | waiting for backend read data (busy low)
// WR_REQ  | write strobe held until backend raises busy
// WR_WAIT | waiting for backend write completion
// DONE    | release stall, pulse o_valid for completed reads
module unaligned_mem_adapter
  import uma_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst_x,
  input  logic            i_rd_en,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_data,
  input  logic [2:0]      i_ctrl,
  output logic [DW-1:0]   o_data,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_misalign,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_be,
  input  logic [DW-1:0]   i_mem_rdata,
  input  logic            i_mem_busy
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

`ifdef UMA_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e          state, state_nxt;
  logic            stall_q, rd_q, cross_q, second_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q, word0_q, align_w0, load_res;
  logic [2:0]      ctrl_q;
  logic [OW-1:0]   off_q;
  logic            accept, cross_now, trap_now;
  logic [15:0]     be_wide;
  logic [2*DW-1:0] wdata_wide;

  assign o_busy    = stall_q | i_mem_busy;
  assign accept    = (state == IDLE) & (i_rd_en | i_wr_en) & ~o_busy;
  assign cross_now = (int'(i_addr[OW-1:0]) + size_bytes(i_ctrl[1:0], NB)) > NB;
  assign trap_now  = TRAP_EN & cross_now;
  assign off_q     = addr_q[OW-1:0];

  always_ff @(posedge clk) begin
    if (rst_x) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = trap_now ? DONE : (i_rd_en ? RD_REQ : WR_REQ);
      RD_REQ:  if (i_mem_busy) state_nxt = RD_WAIT;
      RD_WAIT: if (!i_mem_busy) state_nxt = (cross_q && !second_q) ? RD_REQ : DONE;
      WR_REQ:  if (i_mem_busy) state_nxt = WR_WAIT;
      WR_WAIT: if (!i_mem_busy) state_nxt = (cross_q && !second_q) ? WR_REQ : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      stall_q  <= 1'b0;
      rd_q     <= 1'b0;
      cross_q  <= 1'b0;
      second_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      word0_q  <= '0;
      o_data   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q   <= i_addr;
          data_q   <= i_data & ({DW{1'b1}} >> (DW - 8 * size_bytes(i_ctrl[1:0], NB)));
          ctrl_q   <= i_ctrl;
          rd_q     <= i_rd_en & ~trap_now;
          cross_q  <= cross_now;
          second_q <= 1'b0;
          stall_q  <= 1'b1;
        end
        RD_WAIT: if (!i_mem_busy) begin
          if (!second_q) word0_q <= i_mem_rdata;
          if (cross_q && !second_q) second_q <= 1'b1;
          else                      o_data   <= load_res;
        end
        WR_WAIT: if (!i_mem_busy && cross_q && !second_q) second_q <= 1'b1;
        DONE:    stall_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // On the final beat the newest word arrives straight from the backend.
  assign align_w0 = second_q ? word0_q : i_mem_rdata;

  uma_load_align #(.DW(DW)) u_load_align (
    .word0       (align_w0),
    .word1       (i_mem_rdata),
    .off         (off_q),
    .size        (ctrl_q[1:0]),
    .is_unsigned (ctrl_q[2]),
    .result      (load_res)
  );

  assign be_wide     = be_mask(ctrl_q[1:0], int'(off_q), NB);
  assign wdata_wide  = {{DW{1'b0}}, data_q} << (8 * int'(off_q));
  assign o_mem_wdata = second_q ? wdata_wide[2*DW-1:DW] : wdata_wide[DW-1:0];
  assign o_mem_addr  = {addr_q[AW-1:OW], {OW{1'b0}}} + (second_q ? AW'(NB) : AW'(0));

  always_comb begin
    o_mem_rd = 1'b0;
    o_mem_wr = 1'b0;
    o_mem_be = '0;
    o_valid  = 1'b0;
    case (state)
      RD_REQ: o_mem_rd = 1'b1;
      WR_REQ: begin
        o_mem_wr = 1'b1;
        o_mem_be = second_q ? NB'(be_wide >> NB) : NB'(be_wide);
      end
      DONE:    o_valid = rd_q;
      default: ;
    endcase
  end

`ifdef UMA_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst_x) misalign_q <= 1'b0;
    else       misalign_q <= accept & cross_now;
  end

  assign o_misalign = misalign_q;
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_unaligned_mem_adapter.sv
// Scoreboard bench for unaligned_mem_adapter (DW=32) against a small
// busy-handshake backend memory model.
module tb_unaligned_mem_adapter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_x = 1'b1;
  logic          i_rd_en = 1'b0, i_wr_en = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data = '0;
  logic [2:0]    i_ctrl = '0;
  logic [DW-1:0] o_data;
  logic          o_valid, o_busy, o_misalign, o_mem_rd, o_mem_wr;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [3:0]    o_mem_be;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          i_mem_busy = 1'b0;

  always #5 clk = ~clk;

  unaligned_mem_adapter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_x(rst_x), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en),
    .i_addr(i_addr), .i_data(i_data), .i_ctrl(i_ctrl),
    .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_misalign(o_misalign),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_rdata(i_mem_rdata), .i_mem_busy(i_mem_busy)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_txq[$];
  logic [31:0] exp_dq[$];
  txn_t        t;
  logic [31:0] d;
  int          n_tests = 0, n_fail = 0, n_mis = 0, ntx = 0, lat_cnt = 0;
  logic [31:0] mem [0:1023];
  logic        take = 1'b0, take_wr = 1'b0;
  logic [31:0] take_addr = '0, take_wdata = '0;
  logic [3:0]  take_be = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  task automatic push_rd(input logic [31:0] a);
    exp_txq.push_back('{wr: 1'b0, addr: a, be: 4'h0, wdata: 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    exp_txq.push_back('{wr: 1'b1, addr: a, be: be, wdata: wd});
  endtask

  task automatic push_data(input logic [31:0] v);
    exp_dq.push_back(v);
  endtask

  // Monitor: compares every backend transaction and every load result.
  always @(negedge clk) begin
    take = 1'b0;
    if (!rst_x) begin
      if ((o_mem_rd || o_mem_wr) && !i_mem_busy) begin
        take       = 1'b1;
        take_wr    = o_mem_wr;
        take_addr  = o_mem_addr;
        take_be    = o_mem_be;
        take_wdata = o_mem_wdata;
        if (exp_txq.size() == 0) begin
          flag("txn", $sformatf("unexpected wr=%0b addr=0x%0h", o_mem_wr, o_mem_addr));
        end else begin
          t = exp_txq.pop_front();
          check("txn_kind_addr", {o_mem_wr, o_mem_addr}, {t.wr, t.addr});
          check("txn_be", o_mem_be, t.be);
          if (t.wr) check("txn_wdata", o_mem_wdata, t.wdata);
        end
      end
      if (o_valid) begin
        if (exp_dq.size() == 0) begin
          flag("load", $sformatf("unexpected o_valid, o_data=0x%0h", o_data));
        end else begin
          d = exp_dq.pop_front();
          check("load_data", o_data, d);
        end
      end
      if (o_misalign) n_mis++;
    end
  end

  // Backend: busy for 2..4 cycles per transaction, data valid as busy falls.
  always @(posedge clk) begin
    if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) i_mem_busy <= 1'b0;
    end else if (take) begin
      i_mem_busy <= 1'b1;
      lat_cnt    <= 2 + (ntx % 3);
      ntx        <= ntx + 1;
      if (take_wr) begin
        for (int b = 0; b < 4; b++)
          if (take_be[b]) mem[take_addr[11:2]][8*b +: 8] <= take_wdata[8*b +: 8];
      end else begin
        i_mem_rdata <= mem[take_addr[11:2]];
      end
    end
  end

  task automatic wait_idle(input string name);
    int k = 0;
    while (o_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (o_busy) flag(name, "timeout waiting for o_busy=0");
  endtask

  // spam: keep a write request raised while the adapter is busy; it must be dropped.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] ctrl, input logic spam);
    int k = 0;
    wait_idle("pre_op");
    i_rd_en = rd; i_wr_en = wr; i_addr = addr; i_data = data; i_ctrl = ctrl;
    @(negedge clk);
    i_rd_en = 1'b0; i_wr_en = spam; i_addr = 32'h300;
    while (o_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    i_wr_en = 1'b0;
    if (o_busy) flag("op_done", $sformatf("timeout on op at 0x%0h", addr));
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, bad;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h200 >> 2] = 32'h11223344;
    mem[32'h204 >> 2] = 32'h55667788;

    repeat (3) @(negedge clk);
    check("rst_o_data", o_data, 32'h0);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_busy", o_busy, 1'b0);
    check("rst_strobes", {o_mem_rd, o_mem_wr, o_misalign}, 3'b000);
    check("rst_o_mem_be", o_mem_be, 4'h0);
    rst_x = 1'b0;
    @(negedge clk);

`ifdef UMA_MISALIGN_TRAP_EN
    push_rd(32'h200); push_data(32'h11223344);
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 1'b0);
    do_op(1'b1, 1'b0, 32'h202, 32'h0, 3'b010, 1'b0);
    repeat (3) @(negedge clk);
    check("misalign_pulses", n_mis, 1);
    check("trap_keeps_o_data", o_data, 32'h11223344);
`else
    push_rd(32'h200); push_data(32'h11223344);
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 1'b0);              // LW
    push_rd(32'h200); push_rd(32'h204); push_data(32'hFFFF8811);
    do_op(1'b1, 1'b0, 32'h203, 32'h0, 3'b001, 1'b0);              // LH crossing
    push_rd(32'h200); push_data(32'h00000033);
    do_op(1'b1, 1'b0, 32'h201, 32'h0, 3'b100, 1'b1);              // LBU, writes spammed while busy
    push_wr(32'h100, 4'b1000, 32'hDD000000); push_wr(32'h104, 4'b0111, 32'h00AABBCC);
    do_op(1'b0, 1'b1, 32'h103, 32'hAABBCCDD, 3'b010, 1'b0);       // SW crossing
    check("o_data_hold_after_write", o_data, 32'h00000033);
    push_wr(32'h100, 4'b1100, 32'h12340000);
    do_op(1'b0, 1'b1, 32'h102, 32'hFFFF1234, 3'b001, 1'b0);       // SH, upper data bits masked
    push_rd(32'h100); push_rd(32'h104); push_data(32'hAABBCC12);
    do_op(1'b1, 1'b0, 32'h103, 32'h0, 3'b010, 1'b0);              // LW crossing readback
    push_rd(32'h204); push_data(32'hFFFFFF88);
    do_op(1'b1, 1'b0, 32'h204, 32'h0, 3'b000, 1'b0);              // LB negative
    push_rd(32'h200); push_data(32'h00001122);
    do_op(1'b1, 1'b0, 32'h202, 32'h0, 3'b001, 1'b0);              // LH positive
    push_rd(32'h204); push_data(32'h00005566);
    do_op(1'b1, 1'b0, 32'h206, 32'h0, 3'b101, 1'b0);              // LHU
    push_rd(32'h200); push_data(32'h11223344);
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 3'b011, 1'b0);              // dword size on 32-bit
    push_rd(32'h204); push_rd(32'h208); push_data(32'h00000055);
    do_op(1'b1, 1'b0, 32'h207, 32'h0, 3'b101, 1'b0);              // LHU crossing
    push_wr(32'h104, 4'b0010, 32'h0000C500);
    do_op(1'b0, 1'b1, 32'h105, 32'h123456C5, 3'b000, 1'b0);       // SB
    push_rd(32'h104); push_data(32'h00AAC5CC);
    do_op(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 1'b0);              // LW readback
    push_rd(32'h200); push_data(32'h11223344);
    do_op(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 3'b010, 1'b0);       // read wins over write

    // Reset during the first-half wait of a crossing LW at 0x202.
    wait_idle("pre_reset");
    push_rd(32'h200);
    i_rd_en = 1'b1; i_addr = 32'h202; i_ctrl = 3'b010;
    @(negedge clk);
    i_rd_en = 1'b0;
    k = 0;
    while (!(i_mem_busy && !o_mem_rd) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) flag("reset_setup", "never reached read wait");
    rst_x = 1'b1;
    @(negedge clk);
    rst_x = 1'b0;
    check("rst_mid_busy_is_mem_busy", o_busy, i_mem_busy);
    check("rst_mid_o_data", o_data, 32'h0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_mem_rd || o_valid || (o_busy !== i_mem_busy)) bad++;
    end
    check("rst_mid_no_second_half", bad, 0);
    check("misalign_tied_low", n_mis, 0);
`endif

    repeat (5) @(negedge clk);
    check("txn_queue_drained", exp_txq.size(), 0);
    check("load_queue_drained", exp_dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unaligned_mem_adapter.md
UNALIGNED_MEM_ADAPTER -- requirements
Module: unaligned_mem_adapter

Interface
REQ-001 SHALL have parameter DW, default 32, CPU and backend data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL derive NB = DW/8, bytes per backend word, as a localparam.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_x  input  1  reset, synchronous, active-high.
REQ-006 i_rd_en  input  1  CPU read request; sampled only when o_busy=0.
REQ-007 i_wr_en  input  1  CPU write request; sampled only when o_busy=0.
REQ-008 i_addr  input  AW  CPU byte address; any alignment.
REQ-009 i_data  input  DW  CPU write data, LSB-justified.
REQ-010 i_ctrl  input  3  [1:0] size: 0 byte, 1 half, 2 word, 3 dword; [2] unsigned load.
REQ-011 o_data  output  DW  load result, extended per i_ctrl.
REQ-012 o_valid  output  1  one-cycle pulse when o_data is updated.
REQ-013 o_busy  output  1  internal stall OR i_mem_busy.
REQ-014 o_misalign  output  1  one-cycle error pulse; present only with UMA_MISALIGN_TRAP_EN.
REQ-015 o_mem_rd / o_mem_wr  output  1 each  backend read/write strobes.
REQ-016 o_mem_addr  output  AW  backend address, always NB-aligned.
REQ-017 o_mem_wdata  output  DW  backend write data, lane-positioned.
REQ-018 o_mem_be  output  NB  backend byte enables, active-high.
REQ-019 i_mem_rdata  input  DW  backend read data; valid when i_mem_busy falls.
REQ-020 i_mem_busy  input  1  backend busy.

Function
REQ-021 Size encoding: byte count S = 1, 2, 4, 8; size 3 with DW=32 SHALL be treated as size 2.
REQ-022 Offset: off = addr mod NB. An access crosses a word when off+S > NB; a crossing access SHALL use two backend transactions: word A = aligned addr, then word A+NB.
REQ-023 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-024 IDLE: i_rd_en takes priority over i_wr_en. On acceptance, latch addr, data and ctrl, set stall, go to RD_REQ or WR_REQ.
REQ-025 RD_REQ / WR_REQ: hold the strobe until i_mem_busy=1 is seen, then deassert it and go to the matching WAIT state.
REQ-026 RD_WAIT / WR_WAIT: on i_mem_busy=0, either start the second transaction if the access crosses and the second half is pending, or go to DONE.
REQ-027 DONE: clear stall, pulse o_valid on reads only, return to IDLE. Minimum occupancy is one cycle.
REQ-028 Write, first word: be = ((1<<S)-1) << off, truncated to NB bits; wdata = data << 8*off.
REQ-029 Write, second word: be = ((1<<S)-1) >> (NB-off); wdata = data >> 8*(NB-off).
REQ-030 Read: capture word0, and word1 when crossing; result = {word1, word0} >> 8*off, truncated to S bytes.
REQ-031 Read extension: zero-extend when ctrl[2]=1, otherwise sign-extend from bit 8*S-1.
REQ-032 o_data SHALL hold its value until the next read completes.
REQ-033 Requests asserted while o_busy=1 SHALL be ignored and not queued.
REQ-034 i_data bits above S bytes SHALL be masked to zero before shifting.

Reset
REQ-035 With rst_x=1, on the next edge: state=IDLE; o_mem_rd, o_mem_wr, o_valid, o_misalign, stall = 0; o_mem_be=0; o_data=0.
REQ-036 Reset mid-operation SHALL abandon the backend transaction; no second half is issued after reset.

Configuration
REQ-037 Macro UMA_MISALIGN_TRAP_EN, when defined: a crossing access issues no backend strobe, pulses o_misalign for one cycle, passes through DONE, and leaves o_valid=0 and o_data unchanged.
REQ-038 When UMA_MISALIGN_TRAP_EN is undefined: crossing accesses are split per REQ-022, and o_misalign is tied to 0.

Structure
REQ-039 Package uma_pkg SHALL hold: the size encodings, the FSM state enum, and a function returning the byte-enable mask for (size, off, NB).
REQ-040 Sub-module uma_load_align SHALL perform the combinational load shift and extension (REQ-030, REQ-031). The FSM stays in the top module.

Verification (DW=32; backend model mem[0x200]=0x11223344, mem[0x204]=0x55667788)
REQ-041 LW 0x200 -> one backend read at 0x200; o_data=0x11223344; o_valid pulses once.
REQ-042 LH signed at 0x203 -> reads at 0x200 then 0x204; o_data=0xFFFF8811. LBU 0x201 -> o_data=0x00000033.
REQ-043 SW 0xAABBCCDD at 0x103 -> write 1: addr 0x100, be 1000, wdata 0xDD000000. Write 2: addr 0x104, be 0111, wdata 0x00AABBCC.
REQ-044 SH 0x1234 at 0x102 -> single write: addr 0x100, be 1100, wdata 0x12340000.
REQ-045 rst_x asserted during RD_WAIT of a crossing LW at 0x202 -> IDLE next cycle; no read at 0x204; o_busy follows i_mem_busy only.
REQ-046 With UMA_MISALIGN_TRAP_EN, LW 0x202 -> o_misalign pulses once; no o_mem_rd; o_valid stays 0.
